demux_14_deser: RTL and testbench

- Registered 1-to-4 demultiplexer/deserializer: the receive-side counterpart of the team's registered 4:1 serializing mux.
- Collects a serial 1-bit stream, one bit per qualified cycle, into a 4-bit word.
- Presents the completed word on a valid/ready output with overrun detection.
- Sits after the chip/bit slicer in the Zigbee receive path, feeding symbol-level logic.

---
 rtl/demux_14_deser.sv | 63 ++++++
 tb/tb_demux_14_deser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux_14_deser.sv
// Registered 1-to-NB_LANES deserializer: packs a qualified serial bit stream into
// words and presents them on a valid/ready output with overrun detection.
module demux_14_deser #(
  parameter int NB_LANES  = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IW = $clog2(NB_LANES)
) (
  input  logic                inClock,
  input  logic                inReset,
  input  logic                inData,
  input  logic                inValid,
  input  logic                inSync,
  input  logic                inReady,
  output logic [NB_LANES-1:0] outData,
  output logic                outValid,
  output logic                outOverrun,
  output logic [IW-1:0]       outIdx
);

  logic [NB_LANES-1:0] asm_q;
  logic [NB_LANES-1:0] asm_next;
  logic [IW-1:0]       bit_idx;
  logic [IW-1:0]       lane;
  logic                complete;
  logic                transfer;
  logic                accept;

  // Handshake: a word moves downstream on every edge where outValid and inReady
  // are both high; outValid stays high and outData stable until that happens.
  always_comb begin
    bit_idx  = inSync ? '0 : outIdx;
    lane     = LSB_FIRST ? bit_idx : (IW'(NB_LANES - 1) - bit_idx);
    asm_next = inSync ? '0 : asm_q;
    asm_next[lane] = inData;
    complete = inValid && !inSync && (outIdx == IW'(NB_LANES - 1));
    transfer = outValid && inReady;
    accept   = complete && (!outValid || inReady);
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      asm_q      <= '0;
      outIdx     <= '0;
      outData    <= '0;
      outValid   <= 1'b0;
      outOverrun <= 1'b0;
    end else begin
      if (inValid) begin
        asm_q  <= asm_next;
        // Power-of-two width makes the increment wrap to lane 0 on completion.
        outIdx <= inSync ? IW'(1) : outIdx + IW'(1);
      end
      outOverrun <= complete && !accept;
      if (accept) begin
        outData  <= asm_next;
        outValid <= 1'b1;
      end else if (transfer) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_14_deser.sv
// Bench for demux_14_deser: one LSB-first and one MSB-first instance share the
// stimulus; a bit-list model of the word-assembly rules predicts every output.
module tb_demux_14_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data = 1'b0;
  logic       valid = 1'b0;
  logic       sync = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] data_l, data_m;
  logic       valid_l, valid_m, ovr_l, ovr_m;
  logic [1:0] idx_l, idx_m;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic       bits_q[$];
  logic [3:0] m_data_l, m_data_m;
  logic       m_valid, m_ovr;
  int         m_idx;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  demux_14_deser #(.NB_LANES(4), .LSB_FIRST(1'b1)) dut_lsb (
    .inClock(clk), .inReset(rst), .inData(data), .inValid(valid),
    .inSync(sync), .inReady(ready), .outData(data_l), .outValid(valid_l),
    .outOverrun(ovr_l), .outIdx(idx_l)
  );

  demux_14_deser #(.NB_LANES(4), .LSB_FIRST(1'b0)) dut_msb (
    .inClock(clk), .inReset(rst), .inData(data), .inValid(valid),
    .inSync(sync), .inReady(ready), .outData(data_m), .outValid(valid_m),
    .outOverrun(ovr_m), .outIdx(idx_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next-cycle outputs derived from the rules on the bit list received so far.
  task automatic model_step();
    logic       done;
    logic [3:0] w_l, w_m;
    done = 1'b0;
    w_l  = '0;
    w_m  = '0;
    if (rst) begin
      bits_q.delete();
      m_data_l = '0; m_data_m = '0; m_valid = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      if (valid) begin
        if (sync) bits_q.delete();
        bits_q.push_back(data);
        if (!sync && bits_q.size() == 4) begin
          done = 1'b1;
          for (int k = 0; k < 4; k++) begin
            w_l[k]     = bits_q[k];
            w_m[3 - k] = bits_q[k];
          end
          bits_q.delete();
        end
      end
      if (m_valid && ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      m_ovr = 1'b0;
      if (done) begin
        if (!m_valid || ready) begin
          m_data_l = w_l; m_data_m = w_m; m_valid = 1'b1;
          exp_q.push_back(w_l);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
    m_idx = bits_q.size();
  endtask

  task automatic compare_all();
    check("data_lsb", data_l, m_data_l);
    check("data_msb", data_m, m_data_m);
    check("valid_lsb", valid_l, m_valid);
    check("valid_msb", valid_m, m_valid);
    check("ovr_lsb", ovr_l, m_ovr);
    check("ovr_msb", ovr_m, m_ovr);
    check("idx_lsb", idx_l, m_idx[1:0]);
    check("idx_msb", idx_m, m_idx[1:0]);
    if (m_valid && exp_q.size() > 0) check("scoreboard_head", data_l, exp_q[0]);
  endtask

  task automatic cyc(input logic v, input logic d, input logic s, input logic r,
                     input logic rs = 1'b0);
    @(negedge clk);
    valid = v; data = d; sync = s; ready = r; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [3:0] w, input logic r);
    for (int k = 0; k < 4; k++) cyc(1'b1, w[k], 1'b0, r);
  endtask

  initial begin
    m_data_l = '0; m_data_m = '0; m_valid = 1'b0; m_ovr = 1'b0; m_idx = 0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_data", data_l, 4'h0);
    check("reset_idx", idx_l, 2'd0);

    // stream 1,0,1,1 with ready held high
    cyc(1'b1, 1'b1, 1'b0, 1'b1); check("idx_seq1", idx_l, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1); check("idx_seq2", idx_l, 2'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1); check("idx_seq3", idx_l, 2'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("basic_lsb", data_l, 4'b1101);
    check("basic_msb", data_m, 4'b1011);
    check("basic_valid", valid_l, 1'b1);
    check("basic_idx_wrap", idx_l, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_drop", valid_l, 1'b0);

    // sparse qualifier: idx holds during gaps
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_idx_frozen", idx_l, 2'd2);
    check("gap_no_early_valid", valid_l, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("gap_word", data_l, 4'b0110);

    // realign mid-word
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("realign_idx_before", idx_l, 2'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("realign_idx_after", idx_l, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("realign_word", data_l, 4'b0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure: second word is dropped
    send_word(4'hA, 1'b0);
    check("bp_first", data_l, 4'hA);
    send_word(4'h5, 1'b0);
    check("bp_hold", data_l, 4'hA);
    check("bp_overrun", ovr_l, 1'b1);
    check("bp_valid", valid_l, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_overrun_pulse", ovr_l, 1'b0);
    check("bp_release", valid_l, 1'b0);

    // transfer and completion on the same edge
    send_word(4'h3, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, k == 2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("simul_data", data_l, 4'hC);
    check("simul_valid", valid_l, 1'b1);
    check("simul_ovr", ovr_l, 1'b0);

    // reset with a partial word and a pending output word
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_data", data_l, 4'h0);
    check("midrst_valid", valid_l, 1'b0);
    check("midrst_idx", idx_l, 2'd0);
    send_word(4'h9, 1'b0);
    check("midrst_fresh_lsb", data_l, 4'h9);
    check("midrst_fresh_msb", data_m, 4'h9);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
